// File: rtl/core_ifu_pf.sv
// Prefetching instruction fetch unit.
// Issues in-order fetches to a variable-latency memory port, buffers
// returned {pc, instr} pairs in a small circular queue and hands them to ID
// over valid/ready. Redirects flush the queue and discard in-flight returns.
module core_ifu_pf #(
    parameter int unsigned     PC_W     = 64,
    parameter int unsigned     INSTR_W  = 32,
    parameter int unsigned     FQ_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000),
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [PC_W-1:0]    req_addr,
    input  logic               rsp_valid,
    input  logic [INSTR_W-1:0] rsp_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);

    // Architectural state
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    rsp_pc;
    logic [CNT_W-1:0]   outst;
    logic [CNT_W-1:0]   drop;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    // Queue storage
    logic [PC_W-1:0]    fq_pc    [FQ_DEPTH];
    logic [INSTR_W-1:0] fq_instr [FQ_DEPTH];

    // Next-state values
    logic [PC_W-1:0]    fetch_pc_n;
    logic [PC_W-1:0]    rsp_pc_n;
    logic [CNT_W-1:0]   outst_n;
    logic [CNT_W-1:0]   drop_n;
    logic [CNT_W-1:0]   count_n;
    logic [PTR_W-1:0]   rd_ptr_n;
    logic [PTR_W-1:0]   wr_ptr_n;

    logic [CNT_W:0]     in_use;
    logic               credit_ok;
    logic               issue;
    logic               push;
    logic               pop;
    logic [PC_W-1:0]    redir_pc;
    logic               unused_redir_lo;

    // Redirect targets are word aligned; the low address bits are ignored.
    assign redir_pc        = {redirect_pc[PC_W-1:2], 2'b00};
    assign unused_redir_lo = ^redirect_pc[1:0];

    // Queue slots plus in-flight requests never exceed the queue depth, so
    // every response that is kept always finds a free slot.
    assign in_use    = {1'b0, count} + {1'b0, outst};
    assign credit_ok = in_use < (CNT_W + 1)'(FQ_DEPTH);

    assign req_valid = !rst && !redirect_valid && credit_ok;
    assign req_addr  = fetch_pc;
    assign issue     = req_valid && req_ready;

    assign push = rsp_valid && !redirect_valid && (drop == '0);
    assign pop  = out_valid && out_ready && !redirect_valid;

    assign out_pc    = fq_pc[rd_ptr];
    assign out_instr = fq_instr[rd_ptr];

    // Next-state: redirect has priority over issue, response and pop.
    always_comb begin
        fetch_pc_n = fetch_pc;
        rsp_pc_n   = rsp_pc;
        outst_n    = outst;
        drop_n     = drop;
        count_n    = count;
        rd_ptr_n   = rd_ptr;
        wr_ptr_n   = wr_ptr;

        if (redirect_valid) begin
            fetch_pc_n = redir_pc;
            rsp_pc_n   = redir_pc;
            outst_n    = outst - CNT_W'(rsp_valid);
            drop_n     = outst - CNT_W'(rsp_valid);
            count_n    = '0;
            rd_ptr_n   = '0;
            wr_ptr_n   = '0;
        end else begin
            if (issue) begin
                fetch_pc_n = fetch_pc + PC_W'(PC_STEP);
            end
            outst_n = outst + CNT_W'(issue) - CNT_W'(rsp_valid);
            if (rsp_valid && (drop != '0)) begin
                drop_n = drop - CNT_W'(1);
            end
            if (push) begin
                rsp_pc_n = rsp_pc + PC_W'(PC_STEP);
                wr_ptr_n = wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_n = rd_ptr + PTR_W'(1);
            end
            count_n = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            rsp_pc    <= RESET_PC;
            outst     <= '0;
            drop      <= '0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            fetch_pc  <= fetch_pc_n;
            rsp_pc    <= rsp_pc_n;
            outst     <= outst_n;
            drop      <= drop_n;
            count     <= count_n;
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr_ptr_n;
            out_valid <= (count_n != '0);
        end
    end

    // Queue storage write; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fq_pc[wr_ptr]    <= rsp_pc;
            fq_instr[wr_ptr] <= rsp_instr;
        end
    end

    // Memory must never return more responses than were requested.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rsp_valid && (outst == '0)));
        end
    end

endmodule
